// File: rtl/ca1_recall_comparator.sv
// ca1_recall_comparator: scores each CA3 recall episode against the EC pattern captured at
// recall onset, keeps saturating episode statistics and flags novelty after a mismatch run.
`default_nettype none

module ca1_recall_comparator #(
  parameter int N_UNITS       = 6,
  parameter int MATCH_THRESH  = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int NOVEL_RUN     = 3,
  parameter int CNT_W         = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clk_en,
  input  logic [N_UNITS-1:0]             ec_pattern,
  input  logic [N_UNITS-1:0]             phase_pattern,
  input  logic                           learning,
  input  logic                           recalling,
  output logic                           valid,
  output logic                           match,
  output logic                           mismatch,
  output logic [$clog2(N_UNITS+1)-1:0]   hamming,
  output logic [N_UNITS-1:0]             recalled,
  output logic                           novelty,
  output logic [CNT_W-1:0]               recall_count,
  output logic [CNT_W-1:0]               match_count,
  output logic [2:0]                     debug_state
);

  localparam int HW = $clog2(N_UNITS+1);
  localparam int SW = $clog2(SETTLE_CYCLES+1);
  localparam int RW = $clog2(NOVEL_RUN+1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES-1);
  localparam logic [RW-1:0]    RUN_MAX     = RW'(NOVEL_RUN);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECALL  = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3
  } state_t;

  state_t              state;
  logic [N_UNITS-1:0]  target_q;
  logic [SW-1:0]       settle_cnt;
  logic [RW-1:0]       run;

  function automatic logic [HW-1:0] popcount(input logic [N_UNITS-1:0] v);
    logic [HW-1:0] acc;
    acc = '0;
    for (int i = 0; i < N_UNITS; i++) acc = acc + HW'(v[i]);
    return acc;
  endfunction

  logic [HW-1:0] ham_now;
  logic          match_now;

  // An all-zero recall never counts as a match, even against an all-zero target.
  assign ham_now   = popcount(phase_pattern ^ target_q);
  assign match_now = (int'(ham_now) <= MATCH_THRESH) && (|phase_pattern);

  assign novelty     = (run == RUN_MAX);
  assign debug_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      target_q     <= '0;
      settle_cnt   <= '0;
      run          <= '0;
      valid        <= 1'b0;
      match        <= 1'b0;
      mismatch     <= 1'b0;
      hamming      <= '0;
      recalled     <= '0;
      recall_count <= '0;
      match_count  <= '0;
    end else begin
      valid <= 1'b0;
      if (clk_en) begin
        if (learning) begin
          // Learning wins everywhere: abort any episode without a verdict.
          run   <= '0;
          state <= IDLE;
        end else begin
          case (state)
            IDLE: begin
              if (recalling) begin
                target_q <= ec_pattern;
                state    <= RECALL;
              end
            end
            RECALL: begin
              if (!recalling) begin
                settle_cnt <= '0;
                state      <= SETTLE;
              end
            end
            SETTLE: begin
              settle_cnt <= settle_cnt + 1'b1;
              if (settle_cnt == SETTLE_LAST) state <= COMPARE;
            end
            COMPARE: begin
              recalled <= phase_pattern;
              hamming  <= ham_now;
              match    <= match_now;
              mismatch <= ~match_now;
              valid    <= 1'b1;
              if (recall_count != CNT_MAX) recall_count <= recall_count + 1'b1;
              if (match_now) begin
                run <= '0;
                if (match_count != CNT_MAX) match_count <= match_count + 1'b1;
              end else if (run != RUN_MAX) begin
                run <= run + 1'b1;
              end
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ca1_recall_comparator.sv
// tb_ca1_recall_comparator: randomized episodes scored by an episode-level reference model;
// a second instance with CNT_W=2 exercises counter saturation.
`default_nettype none

module tb_ca1_recall_comparator;

  localparam int SC = 2;
  localparam int NR = 3;

  logic       clk = 1'b0;
  logic       rst, clk_en, learning, recalling;
  logic [5:0] ec_pattern, phase_pattern;

  logic       valid, match, mismatch, novelty;
  logic [2:0] hamming, debug_state;
  logic [5:0] recalled;
  logic [7:0] recall_count, match_count;

  logic       s_valid, s_match, s_mismatch, s_novelty;
  logic [2:0] s_hamming, s_debug_state;
  logic [5:0] s_recalled;
  logic [1:0] s_recall_count, s_match_count;

  ca1_recall_comparator dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ec_pattern(ec_pattern),
    .phase_pattern(phase_pattern), .learning(learning), .recalling(recalling),
    .valid(valid), .match(match), .mismatch(mismatch), .hamming(hamming),
    .recalled(recalled), .novelty(novelty), .recall_count(recall_count),
    .match_count(match_count), .debug_state(debug_state)
  );

  ca1_recall_comparator #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ec_pattern(ec_pattern),
    .phase_pattern(phase_pattern), .learning(learning), .recalling(recalling),
    .valid(s_valid), .match(s_match), .mismatch(s_mismatch), .hamming(s_hamming),
    .recalled(s_recalled), .novelty(s_novelty), .recall_count(s_recall_count),
    .match_count(s_match_count), .debug_state(s_debug_state)
  );

  always #5 clk = ~clk;

  // Episode-level expectations
  int         m_state, m_ham, m_rc, m_mc, m_run;
  logic       m_match, m_mis, m_valid;
  logic [5:0] m_rec;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ham = 0; m_rc = 0; m_mc = 0; m_run = 0;
    m_match = 0; m_mis = 0; m_valid = 0; m_rec = '0;
  endtask

  task automatic check_all();
    int sr, sm;
    sr = (m_rc > 3) ? 3 : m_rc;
    sm = (m_mc > 3) ? 3 : m_mc;
    check("valid",        32'(valid),        32'(m_valid));
    check("match",        32'(match),        32'(m_match));
    check("mismatch",     32'(mismatch),     32'(m_mis));
    check("hamming",      32'(hamming),      32'(m_ham));
    check("recalled",     32'(recalled),     32'(m_rec));
    check("novelty",      32'(novelty),      32'(m_run == NR));
    check("recall_count", 32'(recall_count), 32'(m_rc));
    check("match_count",  32'(match_count),  32'(m_mc));
    check("debug_state",  32'(debug_state),  32'(m_state));
    check("sat_valid",    32'(s_valid),        32'(m_valid));
    check("sat_recall",   32'(s_recall_count), 32'(sr));
    check("sat_match",    32'(s_match_count),  32'(sm));
  endtask

  task automatic tick();
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 2);
    repeat (n) begin
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      check_all();
    end
  endtask

  // abort_at: settle tick index (1..SC+1) at which learning (or rst) interrupts; -1 for none
  task automatic episode(input logic [5:0] ec, input logic [5:0] ph, input int abort_at,
                         input bit use_rst);
    int  h;
    bit  mt;
    learning = 1'b0; recalling = 1'b1; ec_pattern = ec; phase_pattern = 6'($urandom);
    tick(); m_state = 1; check_all(); gap();
    ec_pattern = ~ec;
    tick(); check_all(); gap();
    recalling = 1'b0; phase_pattern = ph;
    tick(); m_state = 2; check_all(); gap();
    for (int k = 1; k <= SC + 1; k++) begin
      if (k == abort_at && use_rst) begin
        @(negedge clk); rst = 1'b1; #1;
        model_reset(); check_all();
        @(negedge clk); rst = 1'b0;
        tick(); check_all(); gap();
        return;
      end
      if (k == abort_at) learning = 1'b1;
      tick();
      if (k == abort_at) begin
        learning = 1'b0; m_state = 0; m_run = 0;
        check_all(); gap();
        return;
      end
      if (k < SC) m_state = 2;
      else if (k == SC) m_state = 3;
      else begin
        h  = $countones(ec ^ ph);
        mt = (h <= 1) && (ph != 6'd0);
        m_ham = h; m_rec = ph; m_match = mt; m_mis = !mt; m_valid = 1'b1;
        if (m_rc < 255) m_rc++;
        if (mt) begin
          m_run = 0;
          if (m_mc < 255) m_mc++;
        end else if (m_run < NR) m_run++;
        m_state = 0;
      end
      check_all(); gap();
    end
  endtask

  task automatic learn_tick(input bit with_recall);
    learning = 1'b1; recalling = with_recall; ec_pattern = 6'($urandom);
    tick(); m_run = 0; m_state = 0; check_all();
    learning = 1'b0; recalling = 1'b0; gap();
  endtask

  initial begin
    logic [5:0] ec, ph;
    int ab;
    rst = 1'b1; clk_en = 1'b0; learning = 1'b0; recalling = 1'b0;
    ec_pattern = '0; phase_pattern = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;

    episode(6'b101010, 6'b101010, -1, 0);
    episode(6'b101010, 6'b101000, -1, 0);
    episode(6'b101010, 6'b010101, -1, 0);
    learn_tick(0);
    repeat (3) episode(6'($urandom), 6'b000000, -1, 0);
    learn_tick(1);
    episode(6'b110011, 6'b110011, -1, 0);
    episode(6'b000000, 6'b000000, -1, 0);
    episode(6'b111000, 6'b111000, 1, 0);
    episode(6'b111000, 6'b111000, SC + 1, 0);
    episode(6'b111000, 6'b111000, 1, 1);
    repeat (5) episode(6'b011011, 6'b011010, -1, 0);

    for (int i = 0; i < 40; i++) begin
      ec = 6'($urandom);
      case ($urandom_range(0, 5))
        0: ph = ec;
        1: ph = ec ^ (6'd1 << $urandom_range(0, 5));
        2: ph = 6'd0;
        3: ph = ~ec;
        4: ph = ec ^ 6'b000011;
        default: ph = 6'($urandom);
      endcase
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, SC + 1)) : -1;
      episode(ec, ph, ab, 0);
      if ($urandom_range(0, 6) == 0) learn_tick(1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
